// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared state encodings, error codes and defaults for uart_packet_rx
package uart_pkt_pkg;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PAYLOAD = 3'd1;
   localparam logic [2:0] S_TERM    = 3'd2;
   localparam logic [2:0] S_CHK     = 3'd3;
   localparam logic [2:0] S_RESYNC  = 3'd4;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_BAD_TERM = 3'd1,
      ERR_TIMEOUT  = 3'd2,
      ERR_BREAK    = 3'd3,
      ERR_BAD_CHK  = 3'd4
   } err_code_e;

   localparam logic [7:0] DEF_TERMINATOR = 8'h0A;
endpackage

// File: rtl/uart_packet_rx_timer.sv
// pkt_timeout_timer: counts cycles since the last byte; expired marks the last allowed cycle
module pkt_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 2700000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);
   localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt;
   // The byte's own cycle counts as 0, so the count reads k in the k-th cycle after it
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= CW'(1);
      else if (en && cnt != LAST) cnt <= cnt + 1'b1;
   end
   assign expired = en && !load && cnt == LAST;
endmodule

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: frames uart_rx bytes into NUM_BYTES-byte packets closed by TERMINATOR.
// Define UART_PKT_CHECKSUM_EN to require an XOR checksum byte between payload and terminator.
module uart_packet_rx
   import uart_pkt_pkg::*;
#(
   parameter int PAYLOAD_BITS = 8,
   parameter int NUM_BYTES = 3,
   parameter logic [PAYLOAD_BITS-1:0] TERMINATOR = PAYLOAD_BITS'(DEF_TERMINATOR),
   parameter int TIMEOUT_CYCLES = 2700000
) (
   input  logic clk,
   input  logic reset_uart,
   input  logic i_rx_valid,
   input  logic [PAYLOAD_BITS-1:0] i_rx_data,
   input  logic i_rx_break,
   output logic [NUM_BYTES*PAYLOAD_BITS-1:0] o_pkt_data,
   output logic o_pkt_valid,
   output logic o_pkt_err,
   output logic [2:0] o_err_code,
   output logic o_busy
);
   localparam int DW = NUM_BYTES * PAYLOAD_BITS;
   localparam int IW = $clog2(NUM_BYTES + 1);
`ifdef UART_PKT_CHECKSUM_EN
   localparam logic [2:0] S_AFTER = S_CHK;
   logic [PAYLOAD_BITS-1:0] chk;
`else
   localparam logic [2:0] S_AFTER = S_TERM;
`endif
   logic [2:0] state;
   logic [DW-1:0] shreg;
   logic [DW-1:0] shifted;
   logic [IW-1:0] idx;
   logic expired;

   assign shifted = (shreg << PAYLOAD_BITS) | DW'(i_rx_data);
   assign o_busy = state != S_IDLE;

   pkt_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk(clk),
      .rst(reset_uart),
      .load(i_rx_valid),
      .en(state == S_PAYLOAD || state == S_TERM || state == S_CHK),
      .expired(expired)
   );

   // Priority: break, then a received byte, then timeout expiry
   always_ff @(posedge clk) begin
      if (reset_uart) begin
         state <= S_IDLE;
         shreg <= '0;
         idx <= '0;
         o_pkt_data <= '0;
         o_pkt_valid <= 1'b0;
         o_pkt_err <= 1'b0;
         o_err_code <= ERR_NONE;
`ifdef UART_PKT_CHECKSUM_EN
         chk <= '0;
`endif
      end else begin
         o_pkt_valid <= 1'b0;
         o_pkt_err <= 1'b0;
         if (i_rx_break && state != S_IDLE) begin
            o_pkt_err <= 1'b1;
            o_err_code <= ERR_BREAK;
            state <= S_IDLE;
         end else if (i_rx_valid) begin
            case (state)
               S_IDLE: if (i_rx_data != TERMINATOR) begin
                  shreg <= DW'(i_rx_data);
                  idx <= IW'(1);
                  state <= NUM_BYTES == 1 ? S_AFTER : S_PAYLOAD;
`ifdef UART_PKT_CHECKSUM_EN
                  chk <= i_rx_data;
`endif
               end
               S_PAYLOAD: begin
                  shreg <= shifted;
                  idx <= idx + 1'b1;
                  if (idx == IW'(NUM_BYTES - 1)) state <= S_AFTER;
`ifdef UART_PKT_CHECKSUM_EN
                  chk <= chk ^ i_rx_data;
`endif
               end
`ifdef UART_PKT_CHECKSUM_EN
               S_CHK: if (i_rx_data == chk) state <= S_TERM;
               else begin
                  o_pkt_err <= 1'b1;
                  o_err_code <= ERR_BAD_CHK;
                  state <= S_RESYNC;
               end
`endif
               S_TERM: if (i_rx_data == TERMINATOR) begin
                  o_pkt_data <= shreg;
                  o_pkt_valid <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  o_pkt_err <= 1'b1;
                  o_err_code <= ERR_BAD_TERM;
                  state <= S_RESYNC;
               end
               default: if (i_rx_data == TERMINATOR) state <= S_IDLE;
            endcase
         end else if (expired) begin
            o_pkt_err <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
            state <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_uart_packet_rx.sv
// tb_uart_packet_rx: randomized scoreboard bench for uart_packet_rx against a frame-level model
`timescale 1ns/1ps
module tb_uart_packet_rx;
   localparam int NB = 3;
   localparam int TO = 100;
`ifdef UART_PKT_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_uart = 1'b1;
   logic i_rx_valid = 1'b0;
   logic i_rx_break = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic [23:0] o_pkt_data;
   logic o_pkt_valid, o_pkt_err, o_busy;
   logic [2:0] o_err_code;

   uart_packet_rx #(.PAYLOAD_BITS(8), .NUM_BYTES(NB), .TERMINATOR(8'h0A), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .reset_uart(reset_uart),
      .i_rx_valid(i_rx_valid),
      .i_rx_data(i_rx_data),
      .i_rx_break(i_rx_break),
      .o_pkt_data(o_pkt_data),
      .o_pkt_valid(o_pkt_valid),
      .o_pkt_err(o_pkt_err),
      .o_err_code(o_err_code),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit err;
      logic [23:0] data;
      logic [2:0] code;
      int at;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int total = 0;
   int bad = 0;

   // Model state: 0 idle, 1 collecting a frame, 2 discarding until terminator
   int mode = 0;
   int last = 0;
   logic [7:0] q[$];
   logic [23:0] good = '0;
   logic [2:0] lcode = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic push(input bit err, input int at, input logic [2:0] code);
      ev_t e;
      if (err) lcode = code;
      e.err = err;
      e.data = good;
      e.code = lcode;
      e.at = at;
      exp_q.push_back(e);
   endtask

   // Byte strobed during cycle s; registered responses appear in cycle s+1
   task automatic model(input logic [7:0] b, input bit brk, input int s);
      logic [7:0] x;
      if (mode == 1 && s - last > TO - 1) begin
         push(1'b1, last + TO, 3'd2);
         mode = 0;
      end
      if (brk && mode != 0) begin
         push(1'b1, s + 1, 3'd3);
         mode = 0;
         return;
      end
      last = s;
      if (mode == 0) begin
         if (b != 8'h0A) begin
            q = {b};
            mode = 1;
         end
      end else if (mode == 2) begin
         if (b == 8'h0A) mode = 0;
      end else if (q.size() < NB) begin
         q.push_back(b);
      end else if (CHK_EN && q.size() == NB) begin
         x = '0;
         foreach (q[i]) x ^= q[i];
         if (x == b) q.push_back(b);
         else begin
            push(1'b1, s + 1, 3'd4);
            mode = 2;
         end
      end else if (b == 8'h0A) begin
         good = '0;
         for (int i = 0; i < NB; i++) good = (good << 8) | 24'(q[i]);
         push(1'b0, s + 1, 3'd0);
         mode = 0;
      end else begin
         push(1'b1, s + 1, 3'd1);
         mode = 2;
      end
   endtask

   // All driver tasks start and end just after a rising edge
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit brk, input int gap);
      model(b, brk, cyc + gap + 1);
      repeat (gap) @(posedge clk);
      @(posedge clk);
      #1;
      i_rx_valid = 1'b1;
      i_rx_data = b;
      i_rx_break = brk;
      @(posedge clk);
      #1;
      i_rx_valid = 1'b0;
      i_rx_break = 1'b0;
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send(a, 1'b0, 0);
      send(b, 1'b0, 1);
      send(c, 1'b0, 0);
`ifdef UART_PKT_CHECKSUM_EN
      send(a ^ b ^ c, 1'b0, 2);
`endif
      send(8'h0A, 1'b0, 0);
      idle(2);
   endtask

   task automatic flush();
      if (mode == 1) push(1'b1, last + TO, 3'd2);
      mode = 0;
      idle(TO + 5);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_uart = 1'b1;
      mode = 0;
      q.delete();
      good = '0;
      lcode = '0;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_uart = 1'b0;
      check("reset_data", 64'(o_pkt_data), 64'(0));
      check("reset_valid", 64'(o_pkt_valid), 64'(0));
      check("reset_err", 64'(o_pkt_err), 64'(0));
      check("reset_code", 64'(o_err_code), 64'(0));
      check("reset_busy", 64'(o_busy), 64'(0));
   endtask

   always @(negedge clk) begin
      if (!reset_uart) begin
         if (o_pkt_valid && o_pkt_err) check("valid_err_overlap", 64'(1), 64'(0));
         if (o_pkt_valid || o_pkt_err) begin
            if (exp_q.size() == 0) check("unexpected_event", 64'({o_pkt_valid, o_pkt_err}), 64'(0));
            else begin
               mon_e = exp_q.pop_front();
               check("event_kind", 64'(o_pkt_err), 64'(mon_e.err));
               check("event_cycle", 64'(cyc), 64'(mon_e.at));
               check("event_data", 64'(o_pkt_data), 64'(mon_e.data));
               check("event_code", 64'(o_err_code), 64'(mon_e.code));
            end
         end else if (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
            check("missing_event", 64'(0), 64'(exp_q[0].at));
            mon_e = exp_q.pop_front();
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r, gap;
      logic [7:0] b;
      do_reset();
      frame(8'h14, 8'h00, 8'h01);
      check("t1_data", 64'(o_pkt_data), 64'h140001);
      check("t1_busy", 64'(o_busy), 64'(0));
      frame(8'h14, 8'h0A, 8'h05);
      check("t2_data", 64'(o_pkt_data), 64'h140A05);
      send(8'h01, 1'b0, 0);
      send(8'h02, 1'b0, 0);
      send(8'h03, 1'b0, 0);
      send(8'h55, 1'b0, 0);
      idle(2);
      check("t3_code", 64'(o_err_code), CHK_EN ? 64'(4) : 64'(1));
      send(8'h07, 1'b0, 0);
      send(8'h0A, 1'b0, 0);
      idle(2);
      check("t3_resync_idle", 64'(o_busy), 64'(0));
      frame(8'h01, 8'h02, 8'h03);
      check("t3_data", 64'(o_pkt_data), 64'h010203);
      check("t3_code_held", 64'(o_err_code), CHK_EN ? 64'(4) : 64'(1));
      send(8'h10, 1'b0, 0);
      idle(3);
      check("t4_busy_wait", 64'(o_busy), 64'(1));
      flush();
      check("t4_busy_after", 64'(o_busy), 64'(0));
      check("t4_code", 64'(o_err_code), 64'(2));
      check("t4_data_held", 64'(o_pkt_data), 64'h010203);
      send(8'h10, 1'b0, 0);
      send(8'h20, 1'b0, 97);
      send(8'h30, 1'b0, 0);
`ifdef UART_PKT_CHECKSUM_EN
      send(8'h00, 1'b0, 0);
`endif
      send(8'h0A, 1'b0, 0);
      idle(2);
      check("t4_edge_data", 64'(o_pkt_data), 64'h102030);
      send(8'h10, 1'b0, 0);
      send(8'h20, 1'b0, 98);
      flush();
      check("t4_late_code", 64'(o_err_code), 64'(2));
      send(8'h01, 1'b0, 0);
      send(8'h02, 1'b0, 0);
      send(8'h33, 1'b1, 0);
      idle(2);
      check("t5_break_code", 64'(o_err_code), 64'(3));
      check("t5_break_idle", 64'(o_busy), 64'(0));
      send(8'h01, 1'b0, 0);
      send(8'h02, 1'b0, 0);
      do_reset();
      frame(8'h21, 8'h22, 8'h23);
      check("t5_after_reset", 64'(o_pkt_data), 64'h212223);
`ifdef UART_PKT_CHECKSUM_EN
      send(8'h14, 1'b0, 0);
      send(8'h00, 1'b0, 0);
      send(8'h01, 1'b0, 0);
      send(8'h15, 1'b0, 0);
      send(8'h0A, 1'b0, 0);
      idle(2);
      check("t6_good", 64'(o_pkt_data), 64'h140001);
      send(8'h14, 1'b0, 0);
      send(8'h00, 1'b0, 0);
      send(8'h01, 1'b0, 0);
      send(8'h16, 1'b0, 0);
      send(8'h0A, 1'b0, 0);
      idle(2);
      check("t6_bad_code", 64'(o_err_code), 64'(4));
      check("t6_data_held", 64'(o_pkt_data), 64'h140001);
`endif
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         gap = r == 0 ? int'($urandom_range(95, 100)) : int'($urandom_range(0, 3));
         b = $urandom_range(0, 3) == 0 ? 8'h0A : 8'($urandom);
         send(b, $urandom_range(0, 24) == 0, gap);
      end
      flush();
      idle(5);
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
